rf_wb_sched: RTL
================

Name: rf_wb_sched

Overview:
- Writeback scheduler and scoreboard for the single-write-port register file.
- Arbitrates N writeback requesters (ALU, load unit, CSR, ...) onto the one write port (a3/we3/wd) with round-robin fairness.
- Tracks destination registers with in-flight writes so the issue stage stalls on RAW/WAW hazards.
- Sits between the execute/memory writeback sources and the register file; the issue stage consults it every cycle.

Parameters:
- N, 3, number of writeback requesters (2..8).
- XLEN, 32, data width of writeback values.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N  requester i has a writeback pending.
- req_rd  in  5*N  destination register of requester i, packed (i*5 +: 5).
- req_data  in  XLEN*N  writeback value of requester i, packed (i*XLEN +: XLEN).
- req_ready  out  N  one-hot grant; transfer occurs when req_valid[i] && req_ready[i].
- rf_a3  out  5  register file write address.
- rf_we3  out  1  register file write enable.
- rf_wd  out  XLEN  register file write data.
- iss_valid  in  1  issue stage presenting an instruction.
- iss_rd  in  5  destination of issuing instruction (0 = none).
- iss_rs1  in  5  source 1.
- iss_rs2  in  5  source 2.
- iss_stall  out  1  issue must hold; the instruction is not recorded.

Behaviour:
- State:
  - rr_ptr (clog2(N) bits).
  - pend[31:1] scoreboard; pend[0] does not exist and always reads 0.
- Reset, checked synchronously at the clock edge:
  - rr_ptr <= 0; pend <= 0.
  - While rst is high, outputs are forced: req_ready=0, rf_we3=0, iss_stall=1, regardless of inputs.
- Arbitration (combinational within the cycle):
  - Search req_valid starting at index rr_ptr, wrapping modulo N; the first valid index g is granted.
  - req_ready = one-hot(g); all zero if no request is valid.
  - At most one grant per cycle.
  - On a grant, rr_ptr <= (g+1) mod N; with no grant, rr_ptr holds.
- Write port:
  - rf_a3 = req_rd[g]; rf_wd = req_data[g].
  - rf_we3 = grant && req_rd[g] != 0.
  - With no grant, rf_a3=0, rf_wd=0, rf_we3=0.
  - Zero latency: the register file captures the write on the same edge as the handshake.
- Stall:
  - iss_stall = iss_valid && (pend[iss_rs1] || pend[iss_rs2] || pend[iss_rd]); index 0 reads as 0.
  - The WAW check on iss_rd ensures at most one in-flight write per register.
- Scoreboard update each edge, with clr_rd = granted rd and set_rd = iss_rd:
  - Clear: if a grant occurs and rd != 0, clear pend[rd].
  - Set: if iss_valid && !iss_stall && iss_rd != 0, set pend[iss_rd].
  - Same register cleared and set in one cycle: set wins, and the register stays pending for the new producer.
- Boundary rules:
  - A writeback to a register that is not pending is legal: it is written and pend is unchanged.
  - rd=0 writebacks are accepted (ready pulses) but never write and never touch the scoreboard.
  - A requester must hold req_valid/rd/data stable until granted; the scheduler does not buffer requests.
  - Reset asserted mid-operation discards all pending state; requesters are reset by the same rst.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Enabled:
  - Stall ignores pend[x] for a source x that equals a register being written this cycle (grant && rf_a3==x && x!=0).
  - Adds outputs fwd1_hit/fwd2_hit (1 bit) and fwd_data (XLEN, = rf_wd) so the decode stage muxes the forwarded value instead of the register file read.
  - WAW on iss_rd is still blocked only if the register remains pending after the clear; the set-wins rule is unchanged.
- Disabled: the ports are absent and stall is exactly as above, so a consumer waits one extra cycle after writeback.

Test Plan:
- Reset: hold rst high for 2 cycles with all req_valid=1 -> req_ready=0, rf_we3=0, iss_stall=1; after release, pend=0 and rr_ptr=0.
- Round-robin, N=3, req_valid=3'b111 held for 3 cycles with rd 5,6,7 -> grants in order 0,1,2; rf_a3 = 5,6,7; rf_we3=1 each cycle.
- Hazard: issue rd=10 (accepted), next cycle issue rs1=10 -> iss_stall=1. Requester 1 writes rd=10 with data 0xDEADBEEF -> rf_we3=1, rf_wd=0xDEADBEEF; on the following cycle iss_stall=0. With RF_WB_BYPASS_EN, the stall drops in the write cycle, fwd1_hit=1 and fwd_data=0xDEADBEEF.
- Simultaneous clear and set on x12: pend[12]=1; writeback rd=12 and issue rd=12 in the same cycle (bypass enabled) -> pend[12]=1 afterwards. Without bypass, the issue stalls and pend[12]=0 afterwards.
- x0: writeback rd=0 with data 0x1234 -> req_ready pulses, rf_we3=0. Issue rd=0, rs1=0 -> never stalls, scoreboard untouched.
- Reset mid-flight: pend[3]=1 and rst pulses for 1 cycle -> pend=0. Issue rs1=3 then no stall.

Source files
------------

// File: rtl/rf_wb_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wb_sched_if
//  Purpose  : Writeback-request, register-file write-port and issue-stage
//             signals of the writeback scheduler (fwd_* with RF_WB_BYPASS_EN).
//  Revision : 1.0 - initial release
// ============================================================================
interface rf_wb_sched_if #(
    parameter int N    = 3,
    parameter int XLEN = 32
);
    logic [N-1:0]      req_valid;
    logic [5*N-1:0]    req_rd;
    logic [XLEN*N-1:0] req_data;
    logic [N-1:0]      req_ready;

    logic [4:0]        rf_a3;
    logic              rf_we3;
    logic [XLEN-1:0]   rf_wd;

    logic              iss_valid;
    logic [4:0]        iss_rd;
    logic [4:0]        iss_rs1;
    logic [4:0]        iss_rs2;
    logic              iss_stall;
`ifdef RF_WB_BYPASS_EN
    logic              fwd1_hit;
    logic              fwd2_hit;
    logic [XLEN-1:0]   fwd_data;
`endif

    modport master (
        output req_valid, req_rd, req_data, iss_valid, iss_rd, iss_rs1, iss_rs2,
        input  req_ready, rf_a3, rf_we3, rf_wd, iss_stall
`ifdef RF_WB_BYPASS_EN
        , input fwd1_hit, fwd2_hit, fwd_data
`endif
    );

    modport slave (
        input  req_valid, req_rd, req_data, iss_valid, iss_rd, iss_rs1, iss_rs2,
        output req_ready, rf_a3, rf_we3, rf_wd, iss_stall
`ifdef RF_WB_BYPASS_EN
        , output fwd1_hit, fwd2_hit, fwd_data
`endif
    );
endinterface
`default_nettype wire

// File: rtl/rf_wb_sched.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wb_sched
//  Purpose  : Round-robin writeback arbiter onto the single RF write port plus
//             a pending-write scoreboard that stalls issue on RAW/WAW hazards.
//             Optional macro RF_WB_BYPASS_EN forwards the write-port value.
//  Revision : 1.0 - initial release
// ============================================================================
module rf_wb_sched #(
    parameter int N    = 3,
    parameter int XLEN = 32
) (
    input  wire logic     clk,
    input  wire logic     rst,
    rf_wb_sched_if.slave  bus
);
    localparam int            PW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] C_LAST = PW'(N - 1);

    logic [PW-1:0]   r_rr_ptr;
    logic [31:0]     r_pend;

    logic            w_gnt;
    logic [PW-1:0]   w_gnt_idx;
    logic [N-1:0]    w_onehot;
    logic [4:0]      w_gnt_rd;
    logic [XLEN-1:0] w_gnt_data;
    int              w_best;
    logic            w_we;
    logic            w_hit1;
    logic            w_hit2;
    logic            w_hitd;
    logic            w_busy1;
    logic            w_busy2;
    logic            w_busyd;
    logic            w_stall;
    logic            w_set;
    logic [31:0]     w_pend_nxt;

    // Search distance of requester i from the round-robin pointer, wrapping mod N.
    function automatic int rr_dist(input int i, input logic [PW-1:0] p);
        int pi;
        pi = int'(p);
        return (i >= pi) ? (i - pi) : (i + N - pi);
    endfunction

    always_comb begin
        w_gnt      = 1'b0;
        w_gnt_idx  = '0;
        w_onehot   = '0;
        w_gnt_rd   = '0;
        w_gnt_data = '0;
        w_best     = 0;
        for (int i = 0; i < N; i++) begin
            if (!rst && bus.req_valid[i] && (!w_gnt || rr_dist(i, r_rr_ptr) < w_best)) begin
                w_gnt       = 1'b1;
                w_best      = rr_dist(i, r_rr_ptr);
                w_gnt_idx   = PW'(i);
                w_onehot    = '0;
                w_onehot[i] = 1'b1;
                w_gnt_rd    = bus.req_rd[i*5 +: 5];
                w_gnt_data  = bus.req_data[i*XLEN +: XLEN];
            end
        end
    end

    assign w_we = w_gnt && (w_gnt_rd != 5'd0);

`ifdef RF_WB_BYPASS_EN
    // A source being written this very cycle is satisfied by the forward path.
    assign w_hit1 = w_we && (w_gnt_rd == bus.iss_rs1);
    assign w_hit2 = w_we && (w_gnt_rd == bus.iss_rs2);
    assign w_hitd = w_we && (w_gnt_rd == bus.iss_rd);
`else
    assign w_hit1 = 1'b0;
    assign w_hit2 = 1'b0;
    assign w_hitd = 1'b0;
`endif

    // r_pend[0] is held at zero, so x0 never reads as busy.
    assign w_busy1 = r_pend[bus.iss_rs1] && !w_hit1;
    assign w_busy2 = r_pend[bus.iss_rs2] && !w_hit2;
    assign w_busyd = r_pend[bus.iss_rd]  && !w_hitd;
    assign w_stall = rst || (bus.iss_valid && (w_busy1 || w_busy2 || w_busyd));
    assign w_set   = bus.iss_valid && !w_stall && (bus.iss_rd != 5'd0);

    // Set is applied after clear so a new producer of the same register wins.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_we) begin
            w_pend_nxt[w_gnt_rd] = 1'b0;
        end
        if (w_set) begin
            w_pend_nxt[bus.iss_rd] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_pend   <= '0;
        end else begin
            if (w_gnt) begin
                r_rr_ptr <= (w_gnt_idx == C_LAST) ? '0 : w_gnt_idx + 1'b1;
            end
            r_pend <= w_pend_nxt;
        end
    end

    assign bus.req_ready = w_onehot;
    assign bus.rf_a3     = w_gnt_rd;
    assign bus.rf_wd     = w_gnt_data;
    assign bus.rf_we3    = w_we;
    assign bus.iss_stall = w_stall;
`ifdef RF_WB_BYPASS_EN
    assign bus.fwd1_hit  = w_hit1;
    assign bus.fwd2_hit  = w_hit2;
    assign bus.fwd_data  = w_gnt_data;
`endif
endmodule
`default_nettype wire
